// File: rtl/tt_wb_sel_pkg.sv
// Shared types and register map for the Wishbone tile-select sequencer.
package tt_wb_sel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIS,
        ST_RST,
        ST_GAP,
        ST_INC_H,
        ST_INC_L,
        ST_ENA
    } sel_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int unsigned CTRL_ENA_BIT = 16;
    localparam int unsigned STATUS_BUSY  = 0;
    localparam int unsigned STATUS_DONE  = 1;
    localparam int unsigned STATUS_IRQEN = 8;

endpackage

// File: rtl/tt_wb_sel_seq_regs.sv
// Wishbone-classic decode, single-cycle ack and register file for tt_wb_sel_seq.
// Optional irq enable bit is built only when TT_WB_SEL_IRQ_EN is defined.
module tt_wb_sel_regs
    import tt_wb_sel_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DIV_RESET = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stb,
    input  logic              i_cyc,
    input  logic              i_we,
    input  logic [3:0]        i_sel,
    input  logic [31:0]       i_adr,
    input  logic [31:0]       i_dat,
    output logic              o_ack,
    output logic [31:0]       o_dat,
    input  logic              i_busy,
    input  logic              i_done,
    input  logic [ADDR_W-1:0] i_count,
    output logic              o_start,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_ena_after,
    output logic [DIV_W-1:0]  o_div,
    output logic              o_done_clr
`ifdef TT_WB_SEL_IRQ_EN
   ,output logic              o_irq_en
`endif
);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic [ADDR_W-1:0] r_target;
    logic              r_ena_after;
    logic [DIV_W-1:0]  r_div;
    logic              w_req;
    logic              w_wr;
    logic [1:0]        w_reg;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    // A request is only taken while ack is low, so ack can never repeat back-to-back.
    assign w_req         = i_stb & i_cyc & ~r_ack;
    assign w_wr          = w_req & i_we;
    assign w_reg         = i_adr[3:2];
    assign w_unused_bits = ^{i_sel, i_adr[31:4], i_adr[1:0], i_dat};

    assign o_start    = w_wr & (w_reg == REG_CTRL) & ~i_busy;
    assign o_done_clr = w_wr & (w_reg == REG_STATUS) & i_dat[STATUS_DONE];

`ifdef TT_WB_SEL_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && (w_reg == REG_STATUS)) begin
            r_irq_en <= i_dat[STATUS_IRQEN];
        end
    end

    assign o_irq_en = r_irq_en;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_CTRL: begin
                w_rdata[ADDR_W-1:0]   = r_target;
                w_rdata[CTRL_ENA_BIT] = r_ena_after;
            end
            REG_STATUS: begin
                w_rdata[STATUS_BUSY]  = i_busy;
                w_rdata[STATUS_DONE]  = i_done;
                w_rdata[ADDR_W+15:16] = i_count;
`ifdef TT_WB_SEL_IRQ_EN
                w_rdata[STATUS_IRQEN] = r_irq_en;
`endif
            end
            REG_DIV:  w_rdata[DIV_W-1:0] = r_div;
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_target    <= '0;
            r_ena_after <= 1'b0;
            r_div       <= DIV_W'(DIV_RESET);
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat <= w_rdata;
            end
            if (o_start) begin
                r_target    <= i_dat[ADDR_W-1:0];
                r_ena_after <= i_dat[CTRL_ENA_BIT];
            end
            if (w_wr && (w_reg == REG_DIV)) begin
                r_div <= i_dat[DIV_W-1:0];
            end
        end
    end

    assign o_ack       = r_ack;
    assign o_dat       = r_dat;
    assign o_target    = r_target;
    assign o_ena_after = r_ena_after;
    assign o_div       = r_div;

endmodule

// File: rtl/tt_wb_sel_seq.sv
// Wishbone slave that sequences mux reset, N increment pulses and tile enable.
// Define TT_WB_SEL_IRQ_EN to add the irq_o output and STATUS irq enable bit.
module tt_wb_sel_seq
    import tt_wb_sel_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DIV_RESET = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ctrl_sel_rst_n,
    output logic        ctrl_sel_inc,
    output logic        ctrl_ena
`ifdef TT_WB_SEL_IRQ_EN
   ,output logic        irq_o
`endif
);

    sel_state_t        r_state;
    logic [DIV_W-1:0]  r_timer;
    logic [ADDR_W-1:0] r_count;
    logic              r_done;
    logic              r_sel_rst_n;
    logic              r_sel_inc;
    logic              r_ena;
    logic              w_start;
    logic [ADDR_W-1:0] w_target;
    logic              w_ena_after;
    logic [DIV_W-1:0]  w_div;
    logic              w_done_clr;
    logic              w_busy;
    logic              w_phase_end;
    logic [ADDR_W-1:0] w_count_nxt;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_phase_end = (r_timer == '0);
    assign w_count_nxt = r_count + 1'b1;

`ifdef TT_WB_SEL_IRQ_EN
    logic w_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_done & w_irq_en;
        end
    end

    assign irq_o = r_irq;
`endif

    tt_wb_sel_regs #(
        .ADDR_W    (ADDR_W),
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stb       (wbs_stb_i),
        .i_cyc       (wbs_cyc_i),
        .i_we        (wbs_we_i),
        .i_sel       (wbs_sel_i),
        .i_adr       (wbs_adr_i),
        .i_dat       (wbs_dat_i),
        .o_ack       (wbs_ack_o),
        .o_dat       (wbs_dat_o),
        .i_busy      (w_busy),
        .i_done      (r_done),
        .i_count     (r_count),
        .o_start     (w_start),
        .o_target    (w_target),
        .o_ena_after (w_ena_after),
        .o_div       (w_div),
        .o_done_clr  (w_done_clr)
`ifdef TT_WB_SEL_IRQ_EN
       ,.o_irq_en    (w_irq_en)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_sel_rst_n <= 1'b1;
            r_sel_inc   <= 1'b0;
            r_ena       <= 1'b0;
        end else begin
            if (w_done_clr) begin
                r_done <= 1'b0;
            end
            if (w_busy && !w_phase_end) begin
                r_timer <= r_timer - 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_ena   <= 1'b0;
                        r_timer <= w_div;
                        r_state <= ST_DIS;
                    end
                end
                ST_DIS: begin
                    if (w_phase_end) begin
                        r_sel_rst_n <= 1'b0;
                        r_timer     <= w_div;
                        r_state     <= ST_RST;
                    end
                end
                ST_RST: begin
                    if (w_phase_end) begin
                        r_sel_rst_n <= 1'b1;
                        r_count     <= '0;
                        r_timer     <= w_div;
                        r_state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_phase_end) begin
                        r_timer <= w_div;
                        if (r_count == w_target) begin
                            r_state <= ST_ENA;
                        end else begin
                            r_sel_inc <= 1'b1;
                            r_state   <= ST_INC_H;
                        end
                    end
                end
                ST_INC_H: begin
                    if (w_phase_end) begin
                        r_sel_inc <= 1'b0;
                        r_timer   <= w_div;
                        r_state   <= ST_INC_L;
                    end
                end
                ST_INC_L: begin
                    // The low half of each pulse doubles as the inter-pulse gap, so
                    // the gap decision is taken here, giving 2 phases per increment.
                    if (w_phase_end) begin
                        r_count <= w_count_nxt;
                        r_timer <= w_div;
                        if (w_count_nxt == w_target) begin
                            r_state <= ST_ENA;
                        end else begin
                            r_sel_inc <= 1'b1;
                            r_state   <= ST_INC_H;
                        end
                    end
                end
                ST_ENA: begin
                    r_ena   <= w_ena_after;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl_sel_rst_n = r_sel_rst_n;
    assign ctrl_sel_inc   = r_sel_inc;
    assign ctrl_ena       = r_ena;

endmodule

// File: tb/tb_tt_wb_sel_seq.sv
// Self-checking bench for tt_wb_sel_seq: directed and random select sequences
// compared cycle by cycle against an arithmetic timing model.
module tb_tt_wb_sel_seq;

    logic        clk;
    logic        rst_n;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ctrl_sel_rst_n;
    logic        ctrl_sel_inc;
    logic        ctrl_ena;
`ifdef TT_WB_SEL_IRQ_EN
    logic        irq_o;
`endif

    int total = 0;
    int bad   = 0;

    tt_wb_sel_seq #(
        .ADDR_W    (10),
        .DIV_W     (8),
        .DIV_RESET (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
`ifdef TT_WB_SEL_IRQ_EN
       ,.irq_o          (irq_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] r, input logic [31:0] d);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = w;
        wbs_adr_i = {28'd0, r, 2'b00};
        wbs_dat_i = d;
    endtask

    task automatic idle();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // Full transfer: ack expected one clock after request, then low the next clock.
    task automatic wb_xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                           output logic [31:0] q);
        int unsigned n;
        drive(w, r, d);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (wbs_ack_o !== 1'b1 && n < 8);
        chk("ack_latency", n, 1);
        q = wbs_dat_o;
        idle();
        @(posedge clk);
        #1;
        chk("ack_single", wbs_ack_o, 0);
    endtask

    // Timing model: k = clocks since the start edge; P = phase length.
    task automatic run_seq(input int unsigned div, input int unsigned t,
                           input logic ea, input int unsigned mode);
        int unsigned p;
        int unsigned len;
        logic        e_rst;
        logic        e_inc;
        logic        e_ena;
        logic [31:0] q;
        p   = div + 1;
        len = 3 * p + 2 * p * t + 1;
        drive(1'b1, 2'd0, {15'd0, ea, 6'd0, t[9:0]});
        @(posedge clk);
        #1;
        chk("start_ack", wbs_ack_o, 1);
        idle();
        for (int unsigned k = 0; k <= len + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            e_rst = !(k >= p && k < 2 * p);
            e_inc = (k >= 3 * p) && (k < 3 * p + 2 * p * t) && (((k - 3 * p) % (2 * p)) < p);
            e_ena = (k >= len) ? ea : 1'b0;
            chk("sel_rst_n", ctrl_sel_rst_n, e_rst);
            chk("sel_inc", ctrl_sel_inc, e_inc);
            chk("ena", ctrl_ena, e_ena);
            if (k == 1) chk("ack_not_repeated", wbs_ack_o, 0);
            if (mode == 1) begin
                if (k == 2) drive(1'b1, 2'd0, 32'h0000_0005);
                if (k == 3) begin
                    chk("busy_write_ack", wbs_ack_o, 1);
                    idle();
                end
            end
            if (mode == 2) begin
                if (k == len - 1) drive(1'b1, 2'd1, 32'h0000_0002);
                if (k == len) begin
                    chk("clr_collide_ack", wbs_ack_o, 1);
                    idle();
                end
            end
        end
        wb_xfer(1'b0, 2'd1, 32'd0, q);
        chk("status_done", q, (t << 16) | 32'h2);
        wb_xfer(1'b0, 2'd0, 32'd0, q);
        chk("ctrl_readback", q, (32'(ea) << 16) | t);
        wb_xfer(1'b1, 2'd1, 32'h0000_0002, q);
        wb_xfer(1'b0, 2'd1, 32'd0, q);
        chk("status_cleared", q, t << 16);
    endtask

    logic [31:0] q;
    int unsigned rdiv;
    int unsigned rt;
    logic        rea;

    initial begin
        rst_n     = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel_rst_n", ctrl_sel_rst_n, 1);
        chk("rst_sel_inc", ctrl_sel_inc, 0);
        chk("rst_ena", ctrl_ena, 0);
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        wb_xfer(1'b0, 2'd1, 32'd0, q);
        chk("status_reset", q, 32'h0);
        wb_xfer(1'b0, 2'd2, 32'd0, q);
        chk("div_reset", q, 32'd4);
        wb_xfer(1'b0, 2'd0, 32'd0, q);
        chk("ctrl_reset", q, 32'h0);

        // DIV=0, target 3, enable after: ena high 10 clocks after start
        wb_xfer(1'b1, 2'd2, 32'd0, q);
        run_seq(0, 3, 1'b1, 0);

        wb_xfer(1'b1, 2'd2, 32'd4, q);
        run_seq(4, 0, 1'b0, 0);

        wb_xfer(1'b1, 2'd2, 32'd1, q);
        run_seq(1, 2, 1'b1, 1);

        wb_xfer(1'b1, 2'd2, 32'd0, q);
        run_seq(0, 2, 1'b0, 2);

        for (int unsigned i = 0; i < 6; i++) begin
            rdiv = $urandom_range(0, 3);
            rt   = $urandom_range(0, 6);
            rea  = 1'($urandom_range(0, 1));
            wb_xfer(1'b1, 2'd2, rdiv, q);
            run_seq(rdiv, rt, rea, 0);
        end

        wb_xfer(1'b1, 2'd2, 32'd0, q);
        run_seq(0, 1023, 1'b1, 0);

        wb_xfer(1'b1, 2'd3, 32'hFFFF_FFFF, q);
        wb_xfer(1'b0, 2'd3, 32'd0, q);
        chk("unmapped_read", q, 32'h0);
        wb_xfer(1'b0, 2'd2, 32'd0, q);
        chk("div_after_unmapped", q, 32'd0);

`ifdef TT_WB_SEL_IRQ_EN
        wb_xfer(1'b1, 2'd1, 32'h0000_0100, q);
        drive(1'b1, 2'd0, 32'h0);
        @(posedge clk);
        #1;
        idle();
        for (int unsigned k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("irq_rise", irq_o, (k >= 5) ? 1'b1 : 1'b0);
        end
        wb_xfer(1'b1, 2'd1, 32'h0000_0102, q);
        chk("irq_fall", irq_o, 0);
        wb_xfer(1'b0, 2'd1, 32'd0, q);
        chk("irq_status", q, 32'h0000_0100);
`endif

        // Reset asserted in the middle of the second increment pulse
        wb_xfer(1'b1, 2'd2, 32'd4, q);
        drive(1'b1, 2'd0, 32'h0001_0003);
        @(posedge clk);
        #1;
        idle();
        repeat (27) @(posedge clk);
        #1;
        chk("inc_before_reset", ctrl_sel_inc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sel_rst_n", ctrl_sel_rst_n, 1);
        chk("midrst_sel_inc", ctrl_sel_inc, 0);
        chk("midrst_ena", ctrl_ena, 0);
        chk("midrst_ack", wbs_ack_o, 0);
        #1 rst_n = 1'b1;
        wb_xfer(1'b0, 2'd2, 32'd0, q);
        chk("midrst_div", q, 32'd4);
        wb_xfer(1'b0, 2'd1, 32'd0, q);
        chk("midrst_status", q, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_quiet_inc", ctrl_sel_inc, 0);
        chk("midrst_quiet_rst", ctrl_sel_rst_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
